// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control stage: ALUOp classes, funct codes,
// ALUOperation codes, sequencer state encoding and the decode result payload.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 4;

  // ALUOp classes from the main control
  localparam logic [2:0] ALUOP_R_TYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADDI   = 3'b100;
  localparam logic [2:0] ALUOP_ORI    = 3'b101;
  localparam logic [2:0] ALUOP_MOV    = 3'b011;

  // R-type funct field values
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  // ALUOperation codes
  localparam logic [CODE_W-1:0] OPER_AND = 4'b0000;
  localparam logic [CODE_W-1:0] OPER_OR  = 4'b0001;
  localparam logic [CODE_W-1:0] OPER_NOR = 4'b0010;
  localparam logic [CODE_W-1:0] OPER_ADD = 4'b0011;
  localparam logic [CODE_W-1:0] OPER_SUB = 4'b0100;
  localparam logic [CODE_W-1:0] OPER_MUL = 4'b0101;
  localparam logic [CODE_W-1:0] OPER_MOV = 4'b1111;
  localparam logic [CODE_W-1:0] OPER_NOP = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  // Result of the combinational decode
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              is_mul;
    logic              is_illegal;
  } dec_t;

endpackage

// File: rtl/alu_control_seq_if.sv
// Bus between main control, ALU control stage and ALU.
// master: drives ALUOp/ALUFunction/Valid/Stall/Flush, observes the registered
//         ALUOperation/OpValid/Busy/MulStart (and Illegal).
// slave:  the ALU control stage.
// ALU_CTRL_ILLEGAL_TRAP_EN adds the sticky Illegal signal.
interface alu_control_seq_if #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned OPER_W  = 4
) ();
  logic [ALUOP_W-1:0] ALUOp;
  logic [FUNCT_W-1:0] ALUFunction;
  logic               Valid;
  logic               Stall;
  logic               Flush;
  logic [OPER_W-1:0]  ALUOperation;
  logic               OpValid;
  logic               Busy;
  logic               MulStart;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic               Illegal;

  modport master (
    output ALUOp, ALUFunction, Valid, Stall, Flush,
    input  ALUOperation, OpValid, Busy, MulStart, Illegal
  );
  modport slave (
    input  ALUOp, ALUFunction, Valid, Stall, Flush,
    output ALUOperation, OpValid, Busy, MulStart, Illegal
  );
`else
  modport master (
    output ALUOp, ALUFunction, Valid, Stall, Flush,
    input  ALUOperation, OpValid, Busy, MulStart
  );
  modport slave (
    input  ALUOp, ALUFunction, Valid, Stall, Flush,
    output ALUOperation, OpValid, Busy, MulStart
  );
`endif
endinterface

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of {ALUOp, ALUFunction} into a 4-bit operation
// code plus is_mul / is_illegal flags.
// Ports: alu_op, funct (in); dec_c (out, combinational).
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec_c
);

  always_comb begin
    dec_c = '{code: OPER_NOP, is_mul: 1'b0, is_illegal: 1'b0};
    if (alu_op == ALUOP_W'(ALUOP_R_TYPE)) begin
      if (funct == FUNCT_W'(FUNCT_AND))      dec_c.code = OPER_AND;
      else if (funct == FUNCT_W'(FUNCT_OR))  dec_c.code = OPER_OR;
      else if (funct == FUNCT_W'(FUNCT_NOR)) dec_c.code = OPER_NOR;
      else if (funct == FUNCT_W'(FUNCT_ADD)) dec_c.code = OPER_ADD;
      else if (funct == FUNCT_W'(FUNCT_SUB)) dec_c.code = OPER_SUB;
      else if (funct == FUNCT_W'(FUNCT_MUL)) begin
        dec_c.code   = OPER_MUL;
        dec_c.is_mul = 1'b1;
      end else begin
        dec_c.is_illegal = 1'b1;
      end
    end else if (alu_op == ALUOP_W'(ALUOP_ADDI)) begin
      dec_c.code = OPER_ADD;
    end else if (alu_op == ALUOP_W'(ALUOP_ORI)) begin
      dec_c.code = OPER_OR;
    end else if (alu_op == ALUOP_W'(ALUOP_MOV)) begin
      dec_c.code = OPER_MOV;
    end else begin
      dec_c.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control stage: decodes the instruction class, holds the
// operation in an ID/EX-style register and sequences multi-cycle MUL with a
// busy handshake. Flush beats Stall beats the MUL hold.
// Ports: clk, reset (async active-low), bus (alu_control_seq_if.slave).
// ALU_CTRL_ILLEGAL_TRAP_EN: undecodable valid encodings set sticky Illegal and
// register OpValid=0; otherwise they issue 1001 with OpValid=1.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned OPER_W     = 4,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_control_seq_if.slave     bus
);

  state_t            state_q, state_d;
  logic [OPER_W-1:0] op_q, op_d;
  logic              ov_q, ov_d;
  logic              busy_q, busy_d;
  logic              ms_q, ms_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ill_q, ill_d;
  dec_t              dec;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .alu_op (bus.ALUOp),
    .funct  (bus.ALUFunction),
    .dec_c  (dec)
  );

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OPER_W'(OPER_NOP);
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      ms_q    <= 1'b0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    ms_d    = 1'b0;
    cnt_d   = cnt_q;
    ill_d   = ill_q;

    if (bus.Flush) begin
      state_d = ST_IDLE;
      op_d    = OPER_W'(OPER_NOP);
      ov_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (bus.Stall) begin
      // everything frozen; MulStart deliberately not re-pulsed
    end else if (state_q == ST_MUL && cnt_q != '0) begin
      // Busy drops in the final MUL cycle so the next op can issue without a gap
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
    end else if (bus.Valid) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      if (dec.is_illegal) begin
        state_d = ST_IDLE;
        op_d    = OPER_W'(OPER_NOP);
        ov_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        ill_d   = 1'b1;
      end else
`endif
      if (dec.is_mul) begin
        state_d = ST_MUL;
        op_d    = OPER_W'(dec.code);
        ov_d    = 1'b1;
        busy_d  = 1'b1;
        ms_d    = 1'b1;
        cnt_d   = CNT_W'(MUL_CYCLES - 1);
      end else begin
        state_d = ST_RUN;
        op_d    = OPER_W'(dec.code);
        ov_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      state_d = ST_IDLE;
      op_d    = OPER_W'(OPER_NOP);
      ov_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  assign bus.ALUOperation = op_q;
  assign bus.OpValid      = ov_q;
  assign bus.Busy         = busy_q;
  assign bus.MulStart     = ms_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign bus.Illegal = ill_q;
`else
  // Illegal tracking has no consumer without the trap
  logic unused_illegal;
  assign unused_illegal = dec.is_illegal ^ ill_q;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios followed by
// random traffic compared against a cycle-level reference model.
module tb_alu_control_seq;

  localparam int unsigned MUL_CYCLES = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // reference model state: remaining MUL output cycles including the current one
  logic [3:0] m_op;
  logic       m_ov;
  logic       m_ms;
  logic       m_ill;
  int         m_left;

  alu_control_seq_if bus ();

  alu_control_seq #(
    .ALUOP_W    (3),
    .FUNCT_W    (6),
    .OPER_W     (4),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference decode: returns {illegal, code}
  function automatic logic [4:0] ref_decode(input logic [2:0] a, input logic [5:0] f);
    logic [8:0] key;
    key = {a, f};
    casez (key)
      9'b111_100100: return 5'b0_0000;
      9'b111_100101: return 5'b0_0001;
      9'b111_100111: return 5'b0_0010;
      9'b111_100000: return 5'b0_0011;
      9'b111_100010: return 5'b0_0100;
      9'b111_011000: return 5'b0_0101;
      9'b100_??????: return 5'b0_0011;
      9'b101_??????: return 5'b0_0001;
      9'b011_??????: return 5'b0_1111;
      default:       return 5'b1_1001;
    endcase
  endfunction

  task automatic model_reset();
    m_op = 4'b1001; m_ov = 1'b0; m_ms = 1'b0; m_ill = 1'b0; m_left = 0;
  endtask

  task automatic model_edge(input logic v, input logic [2:0] a, input logic [5:0] f,
                            input logic s, input logic fl);
    logic [4:0] d;
    logic       trap;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    d = ref_decode(a, f);
    m_ms = 1'b0;
    if (fl) begin
      m_op = 4'b1001; m_ov = 1'b0; m_left = 0;
    end else if (s) begin
      // frozen
    end else if (m_left > 1) begin
      m_left = m_left - 1;
    end else if (v && d[4] && trap) begin
      m_ill = 1'b1; m_op = 4'b1001; m_ov = 1'b0; m_left = 0;
    end else if (v) begin
      m_op = d[3:0]; m_ov = 1'b1;
      if (d[3:0] == 4'b0101) begin
        m_left = MUL_CYCLES; m_ms = 1'b1;
      end else begin
        m_left = 0;
      end
    end else begin
      m_op = 4'b1001; m_ov = 1'b0; m_left = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic eb;
    eb = (m_left > 1);
    checks++;
    assert (bus.ALUOperation === m_op) else begin
      errors++;
      $error("FAIL %s ALUOperation observed=%b expected=%b", tag, bus.ALUOperation, m_op);
    end
    checks++;
    assert (bus.OpValid === m_ov) else begin
      errors++;
      $error("FAIL %s OpValid observed=%b expected=%b", tag, bus.OpValid, m_ov);
    end
    checks++;
    assert (bus.Busy === eb) else begin
      errors++;
      $error("FAIL %s Busy observed=%b expected=%b", tag, bus.Busy, eb);
    end
    checks++;
    assert (bus.MulStart === m_ms) else begin
      errors++;
      $error("FAIL %s MulStart observed=%b expected=%b", tag, bus.MulStart, m_ms);
    end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    checks++;
    assert (bus.Illegal === m_ill) else begin
      errors++;
      $error("FAIL %s Illegal observed=%b expected=%b", tag, bus.Illegal, m_ill);
    end
`endif
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_int({tag, "_op"},   int'(bus.ALUOperation), 9);
    check_int({tag, "_ov"},   int'(bus.OpValid), 0);
    check_int({tag, "_busy"}, int'(bus.Busy), 0);
    check_int({tag, "_ms"},   int'(bus.MulStart), 0);
  endtask

  // Apply inputs, take one edge, update the model and compare
  task automatic cycle(input logic v, input logic [2:0] a, input logic [5:0] f,
                       input logic s, input logic fl, input string tag);
    bus.Valid = v; bus.ALUOp = a; bus.ALUFunction = f; bus.Stall = s; bus.Flush = fl;
    @(posedge clk);
    model_edge(v, a, f, s, fl);
    #1;
    check_model(tag);
  endtask

  int n_mul, n_busy, n_ms;

  task automatic tally();
    if (bus.ALUOperation === 4'b0101 && bus.OpValid === 1'b1) n_mul++;
    if (bus.Busy === 1'b1) n_busy++;
    if (bus.MulStart === 1'b1) n_ms++;
  endtask

  initial begin
    logic [2:0] sw_a [8];
    logic [5:0] sw_f [8];
    int         sw_e [8];
    logic [5:0] r_fn [6];

    bus.Valid = 1'b0; bus.ALUOp = '0; bus.ALUFunction = '0; bus.Stall = 1'b0; bus.Flush = 1'b0;
    model_reset();

    // reset state
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    // single-cycle latency
    cycle(1'b1, 3'b111, 6'b100000, 1'b0, 1'b0, "add");
    check_int("add_code", int'(bus.ALUOperation), 3);

    // decode sweep
    sw_a = '{3'b100, 3'b101, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
    sw_f = '{6'b101010, 6'b000000, 6'b111111, 6'b100111, 6'b100010, 6'b100100, 6'b100101, 6'b000000};
    sw_e = '{3, 1, 15, 2, 4, 0, 1, 9};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, sw_a[i], sw_f[i], 1'b0, 1'b0, "sweep");
      check_int("sweep_code", int'(bus.ALUOperation), sw_e[i]);
    end
    cycle(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, "idle");

    // MUL, ignored inputs while busy, back-to-back AND
    n_mul = 0; n_busy = 0; n_ms = 0;
    cycle(1'b1, 3'b111, 6'b011000, 1'b0, 1'b0, "mul");
    tally();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'b111, 6'b100010, 1'b0, 1'b0, "mul_hold");
      tally();
    end
    cycle(1'b1, 3'b111, 6'b100100, 1'b0, 1'b0, "mul_b2b");
    check_int("mul_cycles", n_mul, 4);
    check_int("mul_busy", n_busy, 3);
    check_int("mul_start", n_ms, 1);
    check_int("b2b_and", int'(bus.ALUOperation), 0);
    check_int("b2b_ov", int'(bus.OpValid), 1);

    // MUL with a 2-cycle stall in the middle
    n_mul = 0; n_busy = 0; n_ms = 0;
    cycle(1'b1, 3'b111, 6'b011000, 1'b0, 1'b0, "smul"); tally();
    cycle(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, "smul"); tally();
    cycle(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, "smul_stall"); tally();
    cycle(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, "smul_stall"); tally();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, "smul"); tally();
    end
    check_int("smul_cycles", n_mul, 6);
    check_int("smul_start", n_ms, 1);
    check_int("smul_busy", n_busy, 5);

    // Flush coincident with a valid ADD
    cycle(1'b1, 3'b101, 6'b000000, 1'b0, 1'b0, "pre_flush");
    cycle(1'b1, 3'b111, 6'b100000, 1'b0, 1'b1, "flush_add");
    check_idle("flush_add");

    // Flush during MUL
    cycle(1'b1, 3'b111, 6'b011000, 1'b0, 1'b0, "fmul");
    cycle(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, "fmul");
    cycle(1'b0, 3'b000, 6'b000000, 1'b1, 1'b1, "flush_mul");
    check_idle("flush_mul");

    // Reset during cycle 2 of a MUL
    cycle(1'b1, 3'b111, 6'b011000, 1'b0, 1'b0, "rmul");
    cycle(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, "rmul");
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_idle("reset_mid_mul");
    @(posedge clk); #2;
    reset = 1'b1;
    cycle(1'b1, 3'b111, 6'b100000, 1'b0, 1'b0, "post_reset_add");
    check_int("post_reset_add", int'(bus.ALUOperation), 3);
    check_int("post_reset_ov", int'(bus.OpValid), 1);

    // Undecodable encoding
    cycle(1'b1, 3'b110, 6'b000000, 1'b0, 1'b0, "undef");
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    check_int("trap_ill", int'(bus.Illegal), 1);
    check_int("trap_ov", int'(bus.OpValid), 0);
    cycle(1'b1, 3'b111, 6'b100000, 1'b0, 1'b0, "trap_sticky");
    check_int("trap_sticky", int'(bus.Illegal), 1);
`else
    check_int("undef_op", int'(bus.ALUOperation), 9);
    check_int("undef_ov", int'(bus.OpValid), 1);
`endif

    // Random traffic
    r_fn = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b011000};
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      logic [5:0] f;
      int         k;
      k = int'($urandom_range(0, 9));
      f = 6'($urandom);
      if (k < 6) begin
        a = 3'b111; f = r_fn[k];
      end else if (k == 6) a = 3'b100;
      else if (k == 7) a = 3'b101;
      else if (k == 8) a = 3'b011;
      else a = 3'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), a, f,
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised ALU control stage for the pipelined MIPS datapath. Decodes {ALUOp, ALUFunction} into a 4-bit ALUOperation and holds it in an ID/EX-style register. Sequences multi-cycle operations (MUL) with a busy/stall handshake. Sits between the main control unit and the ALU, replacing the purely combinational decoder.

## Interface
- ALUOP_W, default 3: width of ALUOp from the main control.
- FUNCT_W, default 6: width of the instruction function field.
- OPER_W, default 4: width of ALUOperation; must be ≥ 4.
- MUL_CYCLES, default 4: total ALU cycles for a MUL; legal range 2..15.
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- ALUOp, input, ALUOP_W: operation class from the main control.
- ALUFunction, input, FUNCT_W: instruction funct field.
- Valid, input, 1: decode inputs carry a real instruction this cycle.
- Stall, input, 1: downstream hazard stall; freezes the output register.
- Flush, input, 1: squash the registered instruction (branch taken).
- ALUOperation, output, OPER_W: registered operation code to the ALU.
- OpValid, output, 1: ALUOperation is valid this cycle.
- Busy, output, 1: multi-cycle op in progress; upstream must hold.
- MulStart, output, 1: one-cycle pulse on the first cycle of a MUL.
- Illegal, output, 1: sticky flag; present only with the trap macro.

## Operation
- Decode, combinational, from {ALUOp, ALUFunction}:
  - R-type, ALUOp=111: funct 100100 AND→0000; 100101 OR→0001; 100111 NOR→0010; 100000 ADD→0011; 100010 SUB→0100; 011000 MUL→0101.
  - ADDI, ALUOp=100 (funct ignored) → 0011.
  - ORI, ALUOp=101 → 0001.
  - MOV, ALUOp=011 → 1111.
  - Anything else → 1001 (default/NOP).
- The code is zero-extended to OPER_W.
- FSM states:
  - IDLE: no valid op.
  - RUN: single-cycle op registered.
  - MUL: counter active.
- Transitions, evaluated when Stall=0:
  - Valid and non-MUL → RUN.
  - Valid and MUL → MUL, counter loaded with MUL_CYCLES-1, MulStart pulses.
  - No Valid → IDLE.
- In MUL:
  - Busy=1. Counter decrements each non-stalled cycle. New inputs are ignored.
  - At counter=0, the next state is taken from the current inputs as from RUN.
- Stall=1: register, state and counter are frozen. Busy stays at its current value.
- Flush=1: has priority over Stall and MUL. The next state is IDLE, OpValid=0, ALUOperation=1001, the counter is cleared and Busy drops.
- Valid with Flush in the same cycle: the incoming op is discarded.
- Reset (at any time, including mid-MUL): state IDLE, ALUOperation=1001, OpValid=0, Busy=0, MulStart=0, counter=0, Illegal=0.

## Timing
- Latency: the decoded op appears one cycle after Valid is sampled at a non-stalled edge.
- MUL:
  - OpValid and ALUOperation=0101 are held for exactly MUL_CYCLES cycles, absent stalls.
  - Busy=1 for the first MUL_CYCLES-1 of those cycles and low in the last, so back-to-back issue loses no cycle.
- MulStart: high only in the first MUL cycle. A stall in that cycle does not re-pulse it.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ALU_CTRL_ILLEGAL_TRAP_EN defined:
  - A Valid, undecodable encoding sets the sticky Illegal flag (cleared only by reset).
  - It registers OpValid=0 instead of issuing 1001.
- Undefined:
  - The Illegal port is absent.
  - Undecodable encodings issue 1001 with OpValid=1.

## Structure
- Shared package alu_ctrl_pkg holds:
  - ALUOp class localparams (R_TYPE=111, ADDI=100, ORI=101, MOV=011).
  - Funct localparams.
  - ALUOperation codes (AND, OR, NOR, ADD, SUB, MUL, MOV, NOP=1001).
  - FSM state encoding.
- One sub-module, alu_ctrl_decode: the pure combinational decode returning the code plus is_mul and is_illegal flags. The sequencer/register logic stays in the top.

## Test plan
- Reset mid-MUL: assert reset low during cycle 2 of a MUL → all outputs are immediately IDLE/1001/0; after release, an ADD (111_100000) gives 0011 with OpValid one cycle later.
- Decode sweep: ADDI (100_xxxxxx) → 0011; ORI → 0001; MOV → 1111; 111_100111 → 0010; 111_100010 → 0100; 000_000000 → 1001.
- MUL with MUL_CYCLES=4: Valid 111_011000 → MulStart for one cycle, Busy high for 3 cycles, 0101 held for 4 cycles; a back-to-back AND issues in cycle 5.
- Stall for 2 cycles in the middle of a MUL → 0101 is held for 6 cycles total and MulStart is not repeated.
- Flush coincident with Valid ADD, and a separate Flush during a MUL → next cycle OpValid=0, ALUOperation=1001, Busy=0.
- Trap macro defined, Valid 110_000000 → Illegal=1 persists, OpValid=0. Without the macro → 1001 with OpValid=1.
